// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: 8-step sequence clocked by DIV falling edges (or an internal
// fast divider in test mode) that produces length, sweep and envelope strobes.
module apu_frame_sequencer #(
    parameter int unsigned FAST_DIV = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic       apuv_4mhz,
    input  logic       apu_reset,
    input  logic       apu_on,
    input  logic       div_bit,
    input  logic       test_fast,
    output logic       tick,
    output logic       length_clk,
    output logic       sweep_clk,
    output logic       env_clk,
    output logic [2:0] step
);

    localparam logic [CNT_W-1:0] FastLast = CNT_W'(FAST_DIV - 1);

    logic             div_q;
    logic             on_q;
    logic             skip_pending;
    logic [CNT_W-1:0] fast_cnt;
    logic             fast_hit;
    logic             div_fall;
    logic             ev;

    always_comb begin
        fast_hit = (fast_cnt == FastLast);
        div_fall = div_q & ~div_bit;
        ev       = apu_on & on_q & (test_fast ? fast_hit : div_fall);
    end

    always_ff @(posedge apuv_4mhz) begin
        if (apu_reset) begin
            div_q        <= 1'b0;
            on_q         <= 1'b0;
            skip_pending <= 1'b0;
            fast_cnt     <= '0;
            step         <= 3'd0;
            tick         <= 1'b0;
            length_clk   <= 1'b0;
            sweep_clk    <= 1'b0;
            env_clk      <= 1'b0;
        end else begin
            div_q      <= div_bit;
            on_q       <= apu_on;
            tick       <= 1'b0;
            length_clk <= 1'b0;
            sweep_clk  <= 1'b0;
            env_clk    <= 1'b0;

            // Held at zero outside test mode so a mode switch always restarts the period.
            if (apu_on && test_fast) begin
                fast_cnt <= fast_hit ? '0 : fast_cnt + 1'b1;
            end else begin
                fast_cnt <= '0;
            end

            if (apu_on && !on_q) begin
                // Enabling with DIV high swallows the first falling edge that follows.
                step         <= 3'd0;
                skip_pending <= div_bit & ~test_fast;
            end else if (ev) begin
                if (skip_pending) begin
                    skip_pending <= 1'b0;
                end else begin
                    tick       <= 1'b1;
                    length_clk <= ~step[0];
                    sweep_clk  <= (step == 3'd2) || (step == 3'd6);
                    env_clk    <= (step == 3'd7);
                    step       <= step + 3'd1;
                end
            end
        end
    end

endmodule
